// File: rtl/snes_pad_tx_if.sv
// Signal bundle between the console/host side and the SNES joypad transmitter.
// The master modport is the console plus input mapper; the slave modport is the pad model.
interface snes_pad_tx_if;
    logic        joy_strb;
    logic        joy1_clk;
    logic        joy2_clk;
    logic        joy2_p6;
    logic [11:0] pad1_btn;
    logic [11:0] pad2_btn;
    logic [11:0] pad3_btn;
    logic [11:0] pad4_btn;
    logic [11:0] pad5_btn;
    logic [1:0]  joy1_di;
    logic [1:0]  joy2_di;

    modport master (
        output joy_strb, joy1_clk, joy2_clk, joy2_p6,
        output pad1_btn, pad2_btn, pad3_btn, pad4_btn, pad5_btn,
        input  joy1_di, joy2_di
    );

    modport slave (
        input  joy_strb, joy1_clk, joy2_clk, joy2_p6,
        input  pad1_btn, pad2_btn, pad3_btn, pad4_btn, pad5_btn,
        output joy1_di, joy2_di
    );
endinterface

// File: rtl/snes_pad_tx.sv
// Controller-side SNES joypad serializer: answers strobe/clock with per-button serial data.
// Define SNES_PAD_MULTITAP_EN to turn port 2 into a 4-pad multitap (pads 2-5).
module snes_pad_tx (
    input  logic          mclk,
    input  logic          rst,
    snes_pad_tx_if.slave  bus
);

`ifdef SNES_PAD_MULTITAP_EN
    localparam int NCH = 5;
`else
    localparam int NCH = 2;
`endif

    logic [15:0]    r_sr  [NCH];
    logic [4:0]     r_cnt [NCH];
    logic [11:0]    w_btn [NCH];
    logic [NCH-1:0] w_shift;
    logic [NCH-1:0] w_bit;

    logic       r_strbPrev;
    logic       r_clk1Prev;
    logic       r_clk2Prev;
    logic [1:0] r_joy1Di;
    logic [1:0] r_joy2Di;

    logic w_load;
    logic w_rise1;
    logic w_rise2;

`ifdef SNES_PAD_MULTITAP_EN
    logic r_p6;
`else
    logic w_unused;
    assign w_unused = ^{bus.joy2_p6, bus.pad3_btn, bus.pad4_btn, bus.pad5_btn};
`endif

    // The cycle in which strobe falls still loads, so a simultaneous clock edge is swallowed.
    assign w_load  = bus.joy_strb | r_strbPrev;
    assign w_rise1 = bus.joy1_clk & ~r_clk1Prev & ~w_load;
    assign w_rise2 = bus.joy2_clk & ~r_clk2Prev & ~w_load;

    always_comb begin
        w_shift    = '0;
        w_btn[0]   = bus.pad1_btn;
        w_btn[1]   = bus.pad2_btn;
        w_shift[0] = w_rise1;
`ifdef SNES_PAD_MULTITAP_EN
        w_btn[2]   = bus.pad3_btn;
        w_btn[3]   = bus.pad4_btn;
        w_btn[4]   = bus.pad5_btn;
        w_shift[1] = w_rise2 & r_p6;
        w_shift[2] = w_rise2 & r_p6;
        w_shift[3] = w_rise2 & ~r_p6;
        w_shift[4] = w_rise2 & ~r_p6;
`else
        w_shift[1] = w_rise2;
`endif
    end

    always_comb begin
        w_bit = '0;
        for (int i = 0; i < NCH; i++) begin
            w_bit[i] = r_sr[i][0] | (r_cnt[i] == 5'd16);
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_strbPrev <= 1'b0;
            r_clk1Prev <= 1'b0;
            r_clk2Prev <= 1'b0;
`ifdef SNES_PAD_MULTITAP_EN
            r_p6       <= 1'b0;
`endif
            for (int i = 0; i < NCH; i++) begin
                r_sr[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_strbPrev <= bus.joy_strb;
            r_clk1Prev <= bus.joy1_clk;
            r_clk2Prev <= bus.joy2_clk;
`ifdef SNES_PAD_MULTITAP_EN
            r_p6       <= bus.joy2_p6;
`endif
            // Ones shift in behind the data so reads past the end return 1.
            for (int i = 0; i < NCH; i++) begin
                if (w_load) begin
                    r_sr[i]  <= {4'b0000, w_btn[i]};
                    r_cnt[i] <= 5'd0;
                end else if (w_shift[i]) begin
                    r_sr[i]  <= {1'b1, r_sr[i][15:1]};
                    r_cnt[i] <= (r_cnt[i] == 5'd16) ? 5'd16 : r_cnt[i] + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_joy1Di <= 2'b00;
            r_joy2Di <= 2'b00;
        end else begin
            r_joy1Di <= {1'b0, w_bit[0]};
`ifdef SNES_PAD_MULTITAP_EN
            // Line 1 high during strobe is the multitap presence signature.
            if (r_p6) begin
                r_joy2Di <= {bus.joy_strb | w_bit[2], w_bit[1]};
            end else begin
                r_joy2Di <= {bus.joy_strb | w_bit[4], w_bit[3]};
            end
`else
            r_joy2Di <= {1'b0, w_bit[1]};
`endif
        end
    end

    assign bus.joy1_di = r_joy1Di;
    assign bus.joy2_di = r_joy2Di;

endmodule
